// File: rtl/aes_output_serializer.sv
// -----------------------------------------------------------------------------
// aes_output_serializer
//
// Output stage of the AES core. Completed result blocks from the round
// datapath are captured into a small block FIFO (DEPTH entries). The head block
// is then streamed to the host bus as NWORDS = BLOCK_W/WORD_W words over a
// valid/ready handshake. The core can therefore start the next block while the
// previous one is still draining.
//
// Ports
//   clk        in   clock, rising edge
//   rst        in   synchronous reset, active-low
//   flush      in   synchronous clear of all buffered blocks, active-high
//   in_valid   in   producer presents a completed block on in_data
//   in_ready   out  block accepted on in_valid && in_ready
//   in_data    in   completed block (BLOCK_W bits)
//   out_valid  out  out_data holds a valid word
//   out_ready  in   consumer takes the word on out_valid && out_ready
//   out_data   out  current word (WORD_W bits), zero when nothing is buffered
//   out_last   out  current word is the final word of its block
//   out_idx    out  index of the current word within its block
//   level      out  number of blocks held, including the one being drained
// -----------------------------------------------------------------------------
module aes_output_serializer #(
    parameter int BLOCK_W   = 128,
    parameter int WORD_W    = 32,
    parameter int DEPTH     = 2,
    parameter int MSW_FIRST = 0,
    localparam int NWORDS   = BLOCK_W / WORD_W,
    localparam int IDX_W    = (NWORDS > 1) ? $clog2(NWORDS) : 1,
    localparam int LVL_W    = $clog2(DEPTH + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [BLOCK_W-1:0] in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WORD_W-1:0]  out_data,
    output logic               out_last,
    output logic [IDX_W-1:0]   out_idx,
    output logic [LVL_W-1:0]   level
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    if ((BLOCK_W % WORD_W) != 0 || NWORDS < 1) begin : g_bad_width
        $error("aes_output_serializer: BLOCK_W must be a non-zero multiple of WORD_W");
    end
    if (DEPTH < 1) begin : g_bad_depth
        $error("aes_output_serializer: DEPTH must be at least 1");
    end

    // Block storage is deliberately left out of reset; count qualifies it.
    logic [BLOCK_W-1:0] mem_q [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] count_q,  count_d;
    logic [IDX_W-1:0] widx_q,   widx_d;

    logic               push;
    logic               pop;
    logic               pop_last;
    logic [BLOCK_W-1:0] head_blk;
    logic [WORD_W-1:0]  head_word;
    int                 sel;

    // Pointers wrap explicitly so non-power-of-two depths work.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(DEPTH - 1)) begin
            return '0;
        end
        return p + PTR_W'(1);
    endfunction

    // in_ready does not look at out_ready: a full FIFO never accepts a block,
    // even if the last word of the head block pops in the same cycle.
    assign in_ready  = rst && !flush && (count_q != LVL_W'(DEPTH));
    assign push      = in_valid && in_ready;
    assign out_valid = (count_q != '0);
    assign out_last  = out_valid && (widx_q == IDX_W'(NWORDS - 1));
    assign pop       = out_valid && out_ready;
    assign pop_last  = pop && out_last;
    assign out_idx   = widx_q;
    assign level     = count_q;

    always_comb begin
        head_blk  = mem_q[rd_ptr_q];
        sel       = (MSW_FIRST != 0) ? (NWORDS - 1 - int'(widx_q)) : int'(widx_q);
        head_word = head_blk[sel*WORD_W +: WORD_W];
        out_data  = out_valid ? head_word : '0;
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        widx_d   = widx_q;
        if (flush) begin
            // The word presented this cycle is dropped even if out_ready is high.
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            widx_d   = '0;
        end else begin
            if (push) begin
                wr_ptr_d = ptr_inc(wr_ptr_q);
            end
            if (pop) begin
                if (out_last) begin
                    widx_d   = '0;
                    rd_ptr_d = ptr_inc(rd_ptr_q);
                end else begin
                    widx_d   = widx_q + IDX_W'(1);
                end
            end
            case ({push, pop_last})
                2'b10:   count_d = count_q + LVL_W'(1);
                2'b01:   count_d = count_q - LVL_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            widx_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            widx_q   <= widx_d;
        end
    end

    // push already excludes reset and flush cycles.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= in_data;
        end
    end

endmodule
